// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate controller.
package mac_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Travels alongside each operand pair until its product is due.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/mac_tag_delay.sv
// Fixed-depth shift register of operand tags, matching MPY latency plus the
// operand register stage.
module mac_tag_delay
    import mac_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    // Shift tags one stage per clock; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mpy_mac_accum.sv
// Multiply-accumulate controller wrapped around an external signed 8x8
// multiplier: registers operands, tracks them through the MPY latency and
// accumulates products into a dot-product result.
module mpy_mac_accum
    import mac_pkg::*;
#(
    parameter int MPY_LAT = 1,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic [OP_W-1:0]   mpy_a,
    output logic [OP_W-1:0]   mpy_b,
    input  logic [PROD_W-1:0] mpy_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               first;
    logic               last_done;
    tag_t               tag_in;
    tag_t               tag_out;
    logic               accept;
    logic               done_hs;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic               cnt_sat;

    assign in_ready  = (state == ACCEPT) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign done_hs   = out_valid && out_ready;

    assign tag_in    = '{valid: accept, last: in_last};

    assign prod_ext  = {{(ACC_W-PROD_W){mpy_product[PROD_W-1]}}, mpy_product};
    assign sum       = acc + prod_ext;
    assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_sat   = &count;

    mac_tag_delay #(
        .DEPTH (1 + MPY_LAT)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Capture operands onto the multiplier inputs on accept, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            mpy_a <= '0;
            mpy_b <= '0;
        end else if (accept) begin
            mpy_a <= in_a;
            mpy_b <= in_b;
        end
    end

    // Accumulate the product whose tag is exiting; first term of a vector
    // loads instead of adding, so no clear cycle is needed between vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            first     <= 1'b1;
            last_done <= 1'b0;
        end else begin
            last_done <= tag_out.valid && tag_out.last;
            if (tag_out.valid) begin
                first <= tag_out.last;
                if (first) begin
                    acc   <= prod_ext;
                    count <= CNT_W'(1);
                end else begin
                    acc <= sum;
                    if (!cnt_sat) begin
                        count <= count + 1'b1;
                    end
                    if (add_ovf || cnt_sat) begin
                        ovf <= 1'b1;
                    end
                end
            end else if (done_hs) begin
                ovf <= 1'b0;
            end
        end
    end

    // Control sequence: accept terms, drain the pipeline, present the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            case (state)
                ACCEPT:  if (accept && in_last) state <= DRAIN;
                DRAIN:   if (last_done)         state <= DONE;
                DONE:    if (out_ready)         state <= ACCEPT;
                default:                        state <= ACCEPT;
            endcase
        end
    end

    assign out_acc   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_mpy_mac_accum.sv
// Scoreboard bench for mpy_mac_accum: two instances (ACC_W=24 and ACC_W=17)
// each with a behavioural MPY model; expected vector results are queued at
// issue time and checked by per-instance monitors on the output handshake.
module tb_mpy_mac_accum;

    localparam int LAT = 1;
    localparam int W0  = 24;
    localparam int W1  = 17;

    typedef struct {
        longint acc;
        longint cnt;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0 signals
    logic               v0 = 1'b0, l0 = 1'b0, rdy0, ov0, ordy0 = 1'b1, ovf0;
    logic signed [7:0]  a0 = '0, b0 = '0, ma0, mb0;
    logic signed [15:0] prod0;
    logic [W0-1:0]      acc0;
    logic [7:0]         cnt0;
    // Instance 1 signals
    logic               v1 = 1'b0, l1 = 1'b0, rdy1, ov1, ordy1 = 1'b1, ovf1;
    logic signed [7:0]  a1 = '0, b1 = '0, ma1, mb1;
    logic signed [15:0] prod1;
    logic [W1-1:0]      acc1;
    logic [7:0]         cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc0 = 0;
    int first_acc_cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int va[$];
    int vb[$];

    mpy_mac_accum #(.MPY_LAT(LAT), .ACC_W(W0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_a(a0), .in_b(b0),
        .in_last(l0), .mpy_a(ma0), .mpy_b(mb0), .mpy_product(prod0),
        .out_valid(ov0), .out_ready(ordy0), .out_acc(acc0), .out_count(cnt0), .out_ovf(ovf0)
    );

    mpy_mac_accum #(.MPY_LAT(LAT), .ACC_W(W1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_b(b1),
        .in_last(l1), .mpy_a(ma1), .mpy_b(mb1), .mpy_product(prod1),
        .out_valid(ov1), .out_ready(ordy1), .out_acc(acc1), .out_count(cnt1), .out_ovf(ovf1)
    );

    // Behavioural MPY: product of the registered operands, LAT cycles later.
    logic signed [15:0] pipe0 [LAT+1];
    logic signed [15:0] pipe1 [LAT+1];
    always @(posedge clk) begin
        pipe0[0] <= ma0 * mb0;
        pipe1[0] <= ma1 * mb1;
        for (int i = 1; i <= LAT; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end
    assign prod0 = (LAT == 0) ? 16'(ma0 * mb0) : pipe0[(LAT == 0) ? 0 : LAT-1];
    assign prod1 = (LAT == 0) ? 16'(ma1 * mb1) : pipe1[(LAT == 0) ? 0 : LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Dot product over the whole vector with wrap-around at width w.
    function automatic exp_t ref_model(input int w, input int as[$], input int bs[$]);
        exp_t   e;
        longint hi;
        longint lo;
        longint s;
        hi = (64'sd1 <<< (w-1)) - 1;
        lo = -(64'sd1 <<< (w-1));
        e.acc = 0;
        e.ovf = 1'b0;
        foreach (as[i]) begin
            s = longint'(as[i] * bs[i]);
            if (i != 0) begin
                s = e.acc + s;
                if (s > hi || s < lo) begin
                    e.ovf = 1'b1;
                    s = s & ((64'sd1 <<< w) - 1);
                    if (s > hi) s = s - (64'sd1 <<< w);
                end
            end
            e.acc = s;
        end
        e.cnt = (as.size() > 255) ? 255 : as.size();
        if (as.size() > 255) e.ovf = 1'b1;
        return e;
    endfunction

    // Scoreboard monitors: compare each presented result on its handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov0 && ordy0) begin
            hs_cyc0 = cyc;
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result0 actual_acc=%0d required=none", $signed(acc0));
            end else begin
                e = q0.pop_front();
                chk("acc0", longint'($signed(acc0)), e.acc);
                chk("count0", longint'(cnt0), e.cnt);
                chk("ovf0", longint'(ovf0), longint'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov1 && ordy1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result1 actual_acc=%0d required=none", $signed(acc1));
            end else begin
                e = q1.pop_front();
                chk("acc1", longint'($signed(acc1)), e.acc);
                chk("count1", longint'(cnt1), e.cnt);
                chk("ovf1", longint'(ovf1), longint'(e.ovf));
            end
        end
    end

    // Present one pair and hold it until accepted; in_valid is left high.
    task automatic send_pair(input int sel, input int a, input int b, input bit last);
        bit done;
        done = 1'b0;
        if (sel == 0) begin
            v0 = 1'b1; a0 = 8'(a); b0 = 8'(b); l0 = last;
        end else begin
            v1 = 1'b1; a1 = 8'(a); b1 = 8'(b); l1 = last;
        end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if ((sel == 0) ? rdy0 : rdy1) begin
                first_acc_cyc = cyc;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout%0d actual=not_accepted required=accepted", sel);
        end
    endtask

    task automatic send_vector(input int sel, input bit expect_result);
        int first_cyc;
        if (expect_result) begin
            if (sel == 0) q0.push_back(ref_model(W0, va, vb));
            else          q1.push_back(ref_model(W1, va, vb));
        end
        first_cyc = 0;
        foreach (va[i]) begin
            send_pair(sel, va[i], vb[i], i == va.size() - 1);
            if (i == 0) first_cyc = first_acc_cyc;
        end
        first_acc_cyc = first_cyc;
    endtask

    task automatic wait_drained(input int sel);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk);
            #1;
            ok = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL result_timeout%0d actual=pending required=drained", sel);
        end
    endtask

    initial begin
        int n;
        int hs_first;
        int len;

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_during_rst", longint'(rdy0), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", longint'(rdy0), 1);
        chk("rst_out_valid", longint'(ov0), 0);
        chk("rst_out_acc", longint'(acc0), 0);
        chk("rst_out_count", longint'(cnt0), 0);
        chk("rst_out_ovf", longint'(ovf0), 0);
        chk("rst_mpy_a", longint'(ma0), 0);

        // Basic three-term vector plus latency
        va = '{3, -2, -128};
        vb = '{4, 5, -128};
        send_vector(0, 1'b1);
        v0 = 1'b0;
        n = 0;
        while (!ov0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_latency", n + 1, 3 + LAT);
        wait_drained(0);

        // Single-term vector
        va = '{-128};
        vb = '{127};
        send_vector(0, 1'b1);
        v0 = 1'b0;
        wait_drained(0);

        // Overflow wrap on the narrow instance, then a clean vector
        va = '{-128, -128, -128, -128};
        vb = '{-128, -128, -128, -128};
        send_vector(1, 1'b1);
        v1 = 1'b0;
        wait_drained(1);
        va = '{10};
        vb = '{10};
        send_vector(1, 1'b1);
        v1 = 1'b0;
        wait_drained(1);

        // Result held while consumer stalls
        ordy0 = 1'b0;
        va = '{5, 7};
        vb = '{6, -3};
        send_vector(0, 1'b1);
        v0 = 1'b0;
        n = 0;
        while (!ov0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", longint'(ov0), 1);
            chk("stall_acc", longint'($signed(acc0)), 9);
            chk("stall_count", longint'(cnt0), 2);
            chk("stall_in_ready", longint'(rdy0), 0);
            @(posedge clk);
            #1;
        end
        ordy0 = 1'b1;
        wait_drained(0);
        va = '{1};
        vb = '{1};
        send_vector(0, 1'b1);
        v0 = 1'b0;
        wait_drained(0);

        // Reset during drain discards the vector
        va = '{100, 50};
        vb = '{100, -2};
        send_vector(0, 1'b0);
        v0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(ov0), 0);
        chk("midrst_out_acc", longint'(acc0), 0);
        chk("midrst_out_count", longint'(cnt0), 0);
        chk("midrst_out_ovf", longint'(ovf0), 0);
        chk("midrst_in_ready", longint'(rdy0), 1);
        chk("midrst_mpy_a", longint'(ma0), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", longint'(ov0), 0);
        va = '{2};
        vb = '{3};
        send_vector(0, 1'b1);
        v0 = 1'b0;
        wait_drained(0);

        // Back-to-back vectors with in_valid held high
        va = '{1, 3};
        vb = '{2, -4};
        send_vector(0, 1'b1);
        va = '{-7, 9, 11};
        vb = '{8, -9, 12};
        send_vector(0, 1'b1);
        hs_first = first_acc_cyc;
        v0 = 1'b0;
        chk("b2b_first_accept_cycle", hs_first, hs_cyc0 + 1);
        wait_drained(0);

        // Randomised vectors
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(1, 6);
            va.delete();
            vb.delete();
            for (int i = 0; i < len; i++) begin
                va.push_back(int'($urandom_range(0, 255)) - 128);
                vb.push_back(int'($urandom_range(0, 255)) - 128);
            end
            send_vector(0, 1'b1);
            if ($urandom_range(0, 1) == 0) v0 = 1'b0;
        end
        v0 = 1'b0;
        wait_drained(0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
